// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory that answers processor load/store
// requests through a small IDLE/WAIT/RESP handshake.
//   - Writes commit at the accept edge and complete one cycle later.
//   - Reads complete RD_WAIT+1 cycles after accept with registered readData.
//   - Word index is address[7:2] taken modulo DEPTH_WORDS.
//   - Storage is not cleared by rst; only the control path and outputs are.
// Optional build macro: ALIGN_CHECK_EN
//   When defined, a request with address[1:0] != 0 is answered one cycle later
//   with resp_valid=1 and err=1 and has no side effects.
//   When undefined, address[1:0] is ignored and err is tied to 0.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 32'd64,
    parameter int RD_WAIT     = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        WR,
    input  logic [7:0]  address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        resp_valid,
    output logic        busy,
    output logic        err
);

    localparam int         IDX_W       = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 32'd1;
    localparam int         WAIT_LOAD_I = (RD_WAIT > 32'd0) ? (RD_WAIT - 32'd1) : 32'd0;
    localparam logic [3:0] WAIT_LOAD   = WAIT_LOAD_I[3:0];
    localparam bit         ZERO_WAIT   = (RD_WAIT == 32'd0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Fold the 6-bit word address into the implemented depth; non power-of-two
    // depths still wrap correctly because a true modulo is used.
    function automatic logic [IDX_W-1:0] wrap_index(input logic [5:0] word);
        logic [31:0] w;
        w = {26'd0, word} % DEPTH_WORDS;
        return w[IDX_W-1:0];
    endfunction

    state_t           state_r;
    logic [3:0]       cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [31:0]      read_data_r;
    logic             resp_valid_r;
    logic             busy_r;
    logic             err_r;
    logic [31:0]      mem_r [DEPTH_WORDS];

    logic             misalign_s;
    logic             mem_wr_s;
    logic [IDX_W-1:0] addr_idx_s;

    assign addr_idx_s = wrap_index(address[7:2]);

`ifdef ALIGN_CHECK_EN
    assign misalign_s = (address[1:0] != 2'b00);
    assign err        = err_r;
`else
    // Byte offset and the error register have no observable effect in this build.
    logic unused_align_s;
    assign unused_align_s = &{1'b0, address[1:0], err_r};
    assign misalign_s     = 1'b0;
    assign err            = 1'b0;
`endif

    // A write commits exactly when it is accepted: idle, not in reset, aligned.
    assign mem_wr_s = !rst && (state_r == IDLE) && req_valid && WR && !misalign_s;

    assign readData   = read_data_r;
    assign resp_valid = resp_valid_r;
    assign busy       = busy_r;

    // Storage array: written at the accept edge, intentionally outside reset.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem_r[addr_idx_s] <= writeData;
        end
    end

    // Request FSM with registered response, busy and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            idx_r        <= '0;
            read_data_r  <= 32'd0;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        if (misalign_s) begin
                            // Rejected access: answer next cycle, no side effects.
                            state_r      <= RESP;
                            busy_r       <= 1'b1;
                            resp_valid_r <= 1'b1;
                            err_r        <= 1'b1;
                        end else if (WR) begin
                            state_r      <= RESP;
                            busy_r       <= 1'b1;
                            resp_valid_r <= 1'b1;
                            err_r        <= 1'b0;
                        end else if (ZERO_WAIT) begin
                            read_data_r  <= mem_r[addr_idx_s];
                            state_r      <= RESP;
                            busy_r       <= 1'b1;
                            resp_valid_r <= 1'b1;
                            err_r        <= 1'b0;
                        end else begin
                            idx_r        <= addr_idx_s;
                            cnt_r        <= WAIT_LOAD;
                            state_r      <= WAIT;
                            busy_r       <= 1'b1;
                            resp_valid_r <= 1'b0;
                            err_r        <= 1'b0;
                        end
                    end else begin
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                        resp_valid_r <= 1'b0;
                        err_r        <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        // Last wait cycle: fetch the latched word into readData.
                        read_data_r  <= mem_r[idx_r];
                        state_r      <= RESP;
                        busy_r       <= 1'b1;
                        resp_valid_r <= 1'b1;
                        err_r        <= 1'b0;
                    end else begin
                        cnt_r        <= cnt_r - 4'd1;
                        state_r      <= WAIT;
                        busy_r       <= 1'b1;
                        resp_valid_r <= 1'b0;
                        err_r        <= 1'b0;
                    end
                end
                RESP: begin
                    // Response pulse lasts one cycle; readData keeps its value.
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    resp_valid_r <= 1'b0;
                    err_r        <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= 4'd0;
                    busy_r       <= 1'b0;
                    resp_valid_r <= 1'b0;
                    err_r        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
// Three instances: u0 (DEPTH 64, RD_WAIT 1), u1 (DEPTH 32, RD_WAIT 3),
// u2 (DEPTH 64, RD_WAIT 0). They share clk and rst; requests are per instance.
module tb_data_mem_responder;

`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid [3];
    logic        wr        [3];
    logic [7:0]  addr      [3];
    logic [31:0] wdata     [3];
    logic [31:0] rdata     [3];
    logic        resp      [3];
    logic        bsy       [3];
    logic        er        [3];

    int vectors;
    int miscompares;

    data_mem_responder #(.DEPTH_WORDS(64), .RD_WAIT(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .WR(wr[0]),
        .address(addr[0]), .writeData(wdata[0]), .readData(rdata[0]),
        .resp_valid(resp[0]), .busy(bsy[0]), .err(er[0])
    );

    data_mem_responder #(.DEPTH_WORDS(32), .RD_WAIT(3)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .WR(wr[1]),
        .address(addr[1]), .writeData(wdata[1]), .readData(rdata[1]),
        .resp_valid(resp[1]), .busy(bsy[1]), .err(er[1])
    );

    data_mem_responder #(.DEPTH_WORDS(64), .RD_WAIT(0)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .WR(wr[2]),
        .address(addr[2]), .writeData(wdata[2]), .readData(rdata[2]),
        .resp_valid(resp[2]), .busy(bsy[2]), .err(er[2])
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int u, input logic w, input logic [7:0] a, input logic [31:0] d);
        req_valid[u] = 1'b1;
        wr[u]        = w;
        addr[u]      = a;
        wdata[u]     = d;
        cyc(1);
        req_valid[u] = 1'b0;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        for (int u = 0; u < 3; u++) begin
            req_valid[u] = 1'b0;
            wr[u]        = 1'b0;
            addr[u]      = 8'h00;
            wdata[u]     = 32'h0;
        end

        // Reset held for two edges, then released.
        cyc(2);
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            chk32($sformatf("rst_rdata_u%0d", u), rdata[u], 32'h0);
            chk1($sformatf("rst_resp_u%0d", u), resp[u], 1'b0);
            chk1($sformatf("rst_busy_u%0d", u), bsy[u], 1'b0);
            chk1($sformatf("rst_err_u%0d", u), er[u], 1'b0);
        end

        // u0: write then read, RD_WAIT=1.
        issue(0, 1'b1, 8'h10, 32'hDEADBEEF);
        chk1("wr_resp", resp[0], 1'b1);
        chk1("wr_busy", bsy[0], 1'b1);
        chk32("wr_rdata_unchanged", rdata[0], 32'h0);
        cyc(1);
        chk1("wr_resp_end", resp[0], 1'b0);
        chk1("wr_busy_end", bsy[0], 1'b0);
        issue(0, 1'b0, 8'h10, 32'h0);
        chk1("rd_wait_resp", resp[0], 1'b0);
        chk1("rd_wait_busy", bsy[0], 1'b1);
        cyc(1);
        chk1("rd_resp", resp[0], 1'b1);
        chk32("rd_data", rdata[0], 32'hDEADBEEF);
        chk1("rd_err", er[0], 1'b0);
        cyc(1);
        chk1("rd_resp_end", resp[0], 1'b0);
        chk32("rd_data_hold", rdata[0], 32'hDEADBEEF);

        // u0: read immediately after write; read held during RESP is not taken early.
        req_valid[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 32'hCAFEF00D;
        cyc(1);
        chk1("raw_wr_resp", resp[0], 1'b1);
        wr[0] = 1'b0;
        cyc(1);
        chk1("raw_idle_resp", resp[0], 1'b0);
        chk1("raw_idle_busy", bsy[0], 1'b0);
        cyc(1);
        req_valid[0] = 1'b0;
        chk1("raw_rd_busy", bsy[0], 1'b1);
        chk1("raw_rd_noresp", resp[0], 1'b0);
        cyc(1);
        chk1("raw_rd_resp", resp[0], 1'b1);
        chk32("raw_rd_data", rdata[0], 32'hCAFEF00D);
        cyc(1);

        // u0: reset during WAIT aborts the read; memory survives.
        issue(0, 1'b0, 8'h10, 32'h0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk1("midrst_resp", resp[0], 1'b0);
        chk32("midrst_rdata", rdata[0], 32'h0);
        chk1("midrst_busy", bsy[0], 1'b0);
        cyc(1);
        chk1("midrst_noresp_late", resp[0], 1'b0);
        issue(0, 1'b0, 8'h10, 32'h0);
        cyc(1);
        chk1("midrst_rd_resp", resp[0], 1'b1);
        chk32("midrst_rd_data", rdata[0], 32'hDEADBEEF);
        cyc(1);

        // u0: misaligned write (err only when alignment checking is built in).
        issue(0, 1'b1, 8'h13, 32'h12345678);
        chk1("mis_resp", resp[0], 1'b1);
        chk1("mis_err", er[0], ALIGN_ON);
        chk32("mis_rdata_unchanged", rdata[0], 32'hDEADBEEF);
        cyc(1);
        issue(0, 1'b0, 8'h10, 32'h0);
        cyc(1);
        chk1("mis_rd_resp", resp[0], 1'b1);
        chk1("mis_rd_err", er[0], 1'b0);
        chk32("mis_rd_data", rdata[0], ALIGN_ON ? 32'hDEADBEEF : 32'h12345678);
        cyc(1);

        // u1: write presented while busy is ignored, single response after 4 cycles.
        issue(1, 1'b1, 8'h10, 32'h0BADF00D);
        cyc(1);
        issue(1, 1'b0, 8'h10, 32'h0);
        req_valid[1] = 1'b1; wr[1] = 1'b1; addr[1] = 8'h10; wdata[1] = 32'h11111111;
        chk1("busy_c1_resp", resp[1], 1'b0);
        chk1("busy_c1_busy", bsy[1], 1'b1);
        cyc(1);
        chk1("busy_c2_resp", resp[1], 1'b0);
        cyc(1);
        chk1("busy_c3_resp", resp[1], 1'b0);
        cyc(1);
        chk1("busy_c4_resp", resp[1], 1'b1);
        chk1("busy_c4_busy", bsy[1], 1'b1);
        chk32("busy_c4_data", rdata[1], 32'h0BADF00D);
        req_valid[1] = 1'b0;
        cyc(1);
        chk1("busy_c5_resp", resp[1], 1'b0);
        chk1("busy_c5_busy", bsy[1], 1'b0);
        cyc(1);
        chk1("busy_c6_resp", resp[1], 1'b0);
        issue(1, 1'b0, 8'h10, 32'h0);
        cyc(3);
        chk1("busy_reread_resp", resp[1], 1'b1);
        chk32("busy_reread_data", rdata[1], 32'h0BADF00D);
        cyc(1);

        // u1: DEPTH_WORDS=32 so byte address 0x80 aliases word 0.
        issue(1, 1'b1, 8'h80, 32'hA5A5A5A5);
        cyc(1);
        issue(1, 1'b0, 8'h00, 32'h0);
        cyc(2);
        chk1("wrap_pre_resp", resp[1], 1'b0);
        cyc(1);
        chk1("wrap_resp", resp[1], 1'b1);
        chk32("wrap_data", rdata[1], 32'hA5A5A5A5);
        cyc(1);

        // u2: RD_WAIT=0 answers the cycle after accept; top word index 63.
        issue(2, 1'b1, 8'h04, 32'h55AA55AA);
        cyc(1);
        issue(2, 1'b0, 8'h04, 32'h0);
        chk1("z_resp", resp[2], 1'b1);
        chk1("z_busy", bsy[2], 1'b1);
        chk32("z_data", rdata[2], 32'h55AA55AA);
        cyc(1);
        chk1("z_resp_end", resp[2], 1'b0);
        chk1("z_busy_end", bsy[2], 1'b0);
        chk32("z_data_hold", rdata[2], 32'h55AA55AA);
        issue(2, 1'b1, 8'hFC, 32'h0F0F0F0F);
        cyc(1);
        issue(2, 1'b0, 8'hFC, 32'h0);
        chk1("z_top_resp", resp[2], 1'b1);
        chk32("z_top_data", rdata[2], 32'h0F0F0F0F);
        cyc(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 32-bit storage words, indexed by address[7:2].
REQ-002 Parameter RD_WAIT, default 1, legal 0..15: extra wait cycles inserted before a read response.
REQ-003 Clock is clk and reset is rst; one clock domain, reset synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  request present this cycle.
REQ-007 WR  input  1  1 = write request, 0 = read request.
REQ-008 address  input  8  byte address from the processor's ALU result.
REQ-009 writeData  input  32  store data, sampled on write accept.
REQ-010 readData  output  32  registered load data, valid when resp_valid=1 for a read.
REQ-011 resp_valid  output  1  one-cycle pulse completing the accepted request.
REQ-012 busy  output  1  high when a new request cannot be accepted.
REQ-013 err  output  1  error qualifier for resp_valid (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP; busy = (state != IDLE).
REQ-015 Accept occurs at a rising edge where state=IDLE and req_valid=1; requests while busy=1 are ignored, and the requester holds them.
REQ-016 Write accept: mem[address[7:2]] <= writeData at the accept edge; FSM goes to RESP; resp_valid=1 in the next cycle; readData unchanged.
REQ-017 Read accept: latch address[7:2]; go to WAIT with a 4-bit counter loaded to RD_WAIT-1, or directly to RESP when RD_WAIT=0.
REQ-018 In WAIT: decrement the counter each cycle; on count 0, load readData <= mem[latched index] and go to RESP.
REQ-019 With RD_WAIT=0, readData SHALL be loaded at the accept edge.
REQ-020 Read response latency: accepted in cycle N gives resp_valid=1 in cycle N+1+RD_WAIT.
REQ-021 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; minimum spacing between accepts is 2 cycles.
REQ-022 readData SHALL hold its last loaded value until the next read response.
REQ-023 Index wrap: address[7:2] >= DEPTH_WORDS SHALL be taken modulo DEPTH_WORDS.
REQ-024 A read of a word written by the immediately preceding request SHALL return the new data.

Reset
REQ-025 While rst=1 at a clock edge: state <= IDLE, counter <= 0, readData <= 0, resp_valid <= 0, err <= 0, and no accept occurs.
REQ-026 Reset during WAIT or RESP SHALL abort the transaction with no response pulse; a write already committed stays committed.
REQ-027 Memory contents SHALL NOT be cleared by rst.

Configuration
REQ-028 Macro ALIGN_CHECK_EN compiles in alignment checking.
REQ-029 With ALIGN_CHECK_EN, a request with address[1:0] != 0 is accepted and goes to RESP next cycle with resp_valid=1 and err=1; no memory write occurs and readData is unchanged. err=0 on all aligned responses.
REQ-030 Without ALIGN_CHECK_EN, address[1:0] is ignored and err SHALL be constant 0.

Verification
REQ-031 Reset: rst=1 for 2 cycles, then release -> readData=0, resp_valid=0, busy=0, err=0.
REQ-032 Write then read: write 0xDEADBEEF to address 0x10 (RD_WAIT=1); read 0x10 -> write resp_valid 1 cycle after accept; read resp_valid 2 cycles after accept with readData=0xDEADBEEF.
REQ-033 Busy ignore: read accepted with RD_WAIT=3, and write 0x11111111 to 0x10 presented while busy=1 and dropped before IDLE -> mem[4] unchanged, exactly one resp_valid pulse after 4 cycles.
REQ-034 Wrap: with DEPTH_WORDS=32, write 0xA5A5A5A5 to 0x80, then read 0x00 -> readData=0xA5A5A5A5.
REQ-035 Mid-op reset: rst asserted in the WAIT cycle of a read of 0x10 -> no resp_valid, readData=0, and a subsequent read of 0x10 returns the previously written data.
REQ-036 ALIGN_CHECK_EN: write 0x12345678 to 0x13 -> resp_valid=1 and err=1 next cycle; a following read of 0x10 returns the prior contents with err=0.
